// File: rtl/gate_response_checker_if.sv
// Signal bundle between a gate_response_checker, its controller and the gate under test.
// The checker takes the slave view; the surrounding environment takes the master view.
interface gate_response_checker_if;
  logic       start;
  logic       dut_out;
  logic       a;
  logic       b;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_count;
  logic       fail_seen;
  logic [1:0] first_fail;

  modport slave (
    input  start, dut_out,
    output a, b, busy, done, pass, err_count, fail_seen, first_fail
  );

  modport master (
    output start, dut_out,
    input  a, b, busy, done, pass, err_count, fail_seen, first_fail
  );
endinterface

// File: rtl/gate_response_checker.sv
// Exhaustive stimulus/response checker for a 2-input combinational gate: walks {a,b} = 00..11,
// samples the gate after SETTLE cycles per vector and compares against the TRUTH table.
module gate_response_checker #(
  parameter logic [3:0]  TRUTH  = 4'b1000,
  parameter int unsigned SETTLE = 2
) (
  input logic                    clk,
  input logic                    rst,
  gate_response_checker_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StWait, StCheck, StDone} state_e;

  localparam logic [3:0] SettleLast = 4'(SETTLE - 1);

  state_e     state_q, state_d;
  logic [1:0] vec_q, vec_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] ab_q, ab_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [2:0] err_q, err_d;
  logic       fs_q, fs_d;
  logic [1:0] ff_q, ff_d;
  logic       mismatch;

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    cnt_d    = cnt_q;
    ab_d     = ab_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    err_d    = err_q;
    fs_d     = fs_q;
    ff_d     = ff_q;
    mismatch = 1'b0;
    unique case (state_q)
      StIdle: begin
        ab_d   = 2'b00;
        busy_d = 1'b0;
        if (bus.start) begin
          state_d = StWait;
          vec_d   = 2'd0;
          cnt_d   = 4'd0;
          err_d   = 3'd0;
          fs_d    = 1'b0;
          ff_d    = 2'd0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      StWait: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == SettleLast) state_d = StCheck;
      end
      StCheck: begin
        mismatch = bus.dut_out != TRUTH[vec_q];
        if (mismatch) begin
          err_d = err_q + 3'd1;
          if (!fs_q) begin
            ff_d = vec_q;
            fs_d = 1'b1;
          end
        end
        if (vec_q == 2'd3) begin
          // pass must see the vector-3 result registered on this same edge
          state_d = StDone;
          ab_d    = 2'b00;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == 3'd0);
        end else begin
          state_d = StWait;
          vec_d   = vec_q + 2'd1;
          ab_d    = vec_q + 2'd1;
          cnt_d   = 4'd0;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      vec_q   <= 2'd0;
      cnt_q   <= 4'd0;
      ab_q    <= 2'b00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 3'd0;
      fs_q    <= 1'b0;
      ff_q    <= 2'd0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      ab_q    <= ab_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fs_q    <= fs_d;
      ff_q    <= ff_d;
    end
  end

  assign bus.a          = ab_q[1];
  assign bus.b          = ab_q[0];
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.err_count  = err_q;
  assign bus.fail_seen  = fs_q;
  assign bus.first_fail = ff_q;

endmodule

// File: tb/tb_gate_response_checker.sv
// Bench for gate_response_checker: three checker instances (default, SETTLE=1, OR truth table)
// each driving a behavioural gate whose function is chosen per run.
module tb_gate_response_checker;

  typedef enum int {GAnd, GOr, GStuck0, GXor, GNand} gate_e;

  typedef struct {
    int         sel;
    int         settle;
    gate_e      mode;
    int         poke;
    logic [2:0] err;
    logic       fs;
    logic [1:0] ff;
    logic       pass;
  } vec_t;

  logic  clk = 1'b0;
  logic  rst;
  logic  start_v [3];
  gate_e mode_v  [3];
  int    sel;
  int    n_cmp = 0;
  int    n_err = 0;
  vec_t  tbl [9];
  vec_t  sb [$];

  logic       o_a, o_b, o_busy, o_done, o_pass, o_fs;
  logic [2:0] o_err;
  logic [1:0] o_ff;

  always #5 clk = ~clk;

  function automatic logic gate_fn(gate_e m, logic a, logic b);
    case (m)
      GAnd:    return a & b;
      GOr:     return a | b;
      GXor:    return a ^ b;
      GNand:   return ~(a & b);
      default: return 1'b0;
    endcase
  endfunction

  gate_response_checker_if if0 ();
  gate_response_checker_if if1 ();
  gate_response_checker_if if2 ();

  assign if0.start   = start_v[0];
  assign if1.start   = start_v[1];
  assign if2.start   = start_v[2];
  assign if0.dut_out = gate_fn(mode_v[0], if0.a, if0.b);
  assign if1.dut_out = gate_fn(mode_v[1], if1.a, if1.b);
  assign if2.dut_out = gate_fn(mode_v[2], if2.a, if2.b);

  gate_response_checker u_dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  gate_response_checker #(.TRUTH(4'b1000), .SETTLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(if1.slave)
  );
  gate_response_checker #(.TRUTH(4'b1110), .SETTLE(2)) u_dut2 (
    .clk(clk), .rst(rst), .bus(if2.slave)
  );

  always_comb begin
    case (sel)
      1: begin
        o_a = if1.a; o_b = if1.b; o_busy = if1.busy; o_done = if1.done;
        o_pass = if1.pass; o_fs = if1.fail_seen; o_err = if1.err_count; o_ff = if1.first_fail;
      end
      2: begin
        o_a = if2.a; o_b = if2.b; o_busy = if2.busy; o_done = if2.done;
        o_pass = if2.pass; o_fs = if2.fail_seen; o_err = if2.err_count; o_ff = if2.first_fail;
      end
      default: begin
        o_a = if0.a; o_b = if0.b; o_busy = if0.busy; o_done = if0.done;
        o_pass = if0.pass; o_fs = if0.fail_seen; o_err = if0.err_count; o_ff = if0.first_fail;
      end
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s (inst %0d, t=%0t): got %0d expected %0d", name, sel, $time, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ab"}, {o_a, o_b}, 0);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_done"}, o_done, 0);
    check({tag, "_pass"}, o_pass, 0);
    check({tag, "_err"}, o_err, 0);
    check({tag, "_fs"}, o_fs, 0);
    check({tag, "_ff"}, o_ff, 0);
  endtask

  // One full run; start is accepted at edge 0 and cycle n is the one after edge n-1.
  task automatic run_vec(input vec_t v);
    int   lat;
    int   n;
    bit   seen;
    vec_t e;
    sel           = v.sel;
    mode_v[v.sel] = v.mode;
    lat           = 4 * (v.settle + 1) + 1;
    start_v[v.sel] = 1'b1;
    sb.push_back(v);
    step();
    start_v[v.sel] = 1'b0;
    seen = 1'b0;
    for (n = 1; n <= lat + 5; n++) begin
      start_v[v.sel] = (n == v.poke);
      if (o_done) begin
        seen = 1'b1;
        break;
      end
      check("busy_run", o_busy, 1);
      check("ab_seq", {o_a, o_b}, (n - 1) / (v.settle + 1));
      step();
    end
    start_v[v.sel] = 1'b0;
    check("done_latency", seen ? n : -1, lat);
    e = sb.pop_front();
    if (seen) begin
      check("busy_done", o_busy, 0);
      check("ab_done", {o_a, o_b}, 0);
      check("err_count", o_err, e.err);
      check("fail_seen", o_fs, e.fs);
      if (e.fs) check("first_fail", o_ff, e.ff);
      check("pass", o_pass, e.pass);
    end
    step();
    check("done_pulse", o_done, 0);
    step();
    check("err_held", o_err, e.err);
    check("pass_held", o_pass, e.pass);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  first;
    int  second;
    bit  seen;
    tbl[0] = '{sel: 0, settle: 2, mode: GAnd,    poke: 0, err: 0, fs: 0, ff: 0, pass: 1};
    tbl[1] = '{sel: 0, settle: 2, mode: GStuck0, poke: 0, err: 1, fs: 1, ff: 3, pass: 0};
    tbl[2] = '{sel: 0, settle: 2, mode: GOr,     poke: 0, err: 2, fs: 1, ff: 1, pass: 0};
    tbl[3] = '{sel: 2, settle: 2, mode: GOr,     poke: 0, err: 0, fs: 0, ff: 0, pass: 1};
    tbl[4] = '{sel: 1, settle: 1, mode: GAnd,    poke: 4, err: 0, fs: 0, ff: 0, pass: 1};
    tbl[5] = '{sel: 2, settle: 2, mode: GAnd,    poke: 0, err: 2, fs: 1, ff: 1, pass: 0};
    tbl[6] = '{sel: 0, settle: 2, mode: GXor,    poke: 0, err: 3, fs: 1, ff: 1, pass: 0};
    tbl[7] = '{sel: 0, settle: 2, mode: GNand,   poke: 0, err: 4, fs: 1, ff: 0, pass: 0};
    tbl[8] = '{sel: 1, settle: 1, mode: GStuck0, poke: 0, err: 1, fs: 1, ff: 3, pass: 0};

    rst = 1'b1;
    sel = 0;
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0;
      mode_v[i]  = GAnd;
    end
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      sel = i;
      check_zero("reset");
    end
    rst = 1'b0;
    step();

    for (int i = 0; i < 9; i++) run_vec(tbl[i]);

    // Reset in cycle 5 of a failing run aborts it without a done pulse.
    sel = 0;
    mode_v[0] = GNand;
    start_v[0] = 1'b1;
    step();
    start_v[0] = 1'b0;
    repeat (3) step();
    check("err_before_rst", o_err, 1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_zero("mid_rst");
    seen = 1'b0;
    repeat (20) begin
      if (o_done) seen = 1'b1;
      step();
    end
    check("no_done_after_rst", seen, 0);
    run_vec(tbl[0]);

    // start together with rst must leave the checker idle.
    rst = 1'b1;
    start_v[0] = 1'b1;
    step();
    check("rst_start_busy", o_busy, 0);
    rst = 1'b0;
    start_v[0] = 1'b0;
    step();
    check("rst_start_idle_busy", o_busy, 0);
    check("rst_start_idle_ab", {o_a, o_b}, 0);

    // start held high: each run is followed by one IDLE cycle, so done pulses 14 cycles apart.
    mode_v[0] = GAnd;
    start_v[0] = 1'b1;
    step();
    first  = -1;
    second = -1;
    for (int n = 1; n <= 40; n++) begin
      if (o_done) begin
        check("b2b_pass_at_done", o_pass, 1);
        if (first < 0) first = n;
        else if (second < 0) second = n;
      end
      if (n == 14) check("b2b_pass_idle", o_pass, 1);
      if (n == 15) check("b2b_pass_cleared", o_pass, 0);
      if (n == 27) start_v[0] = 1'b0;
      step();
    end
    check("b2b_first_done", first, 13);
    check("b2b_second_done", second, 27);
    check("b2b_idle_after", o_busy, 0);
    check("b2b_pass_final", o_pass, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
